// File: rtl/sensor_pkg.sv
// -----------------------------------------------------------------------------
// sensor_pkg
// Shared definitions for the sensor error monitor: default parameter values,
// fixed widths and the monitor FSM state type.
// -----------------------------------------------------------------------------
package sensor_pkg;

    // Default number of consecutive synchronized error samples to raise alarm.
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

    // Default width of the saturating alarm event counter.
    localparam int unsigned COUNT_WIDTH_DEF = 8;

    // Debounce counter width, sized for the largest legal DEBOUNCE_CYCLES (255).
    localparam int unsigned DB_CNT_W = 8;

    // Width of the raw sensor vector.
    localparam int unsigned SENSOR_W = 4;

    // Monitor FSM states. Explicit codes keep the encoding stable for
    // anything that inspects the state register in a waveform or netlist.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ALARM   = 2'd2,
        ST_ACKED   = 2'd3
    } state_e;

endpackage : sensor_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for signals asynchronous to clk. Each bit is
// synchronized independently; both stages reset to 0.
//
// Ports:
//   clk    in   destination clock
//   n_rst  in   asynchronous active-low reset
//   d_i    in   [WIDTH-1:0] asynchronous input
//   q_o    out  [WIDTH-1:0] second-stage (synchronized) output
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so that meta_q and
    // sync_q both update from pre-edge values; blocking here would collapse
    // the two stages into one.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/sensor_error_monitor.sv
// -----------------------------------------------------------------------------
// sensor_error_monitor
// Debounces an asynchronous sensor-fault flag and raises a latched alarm once
// the fault has been seen for DEBOUNCE_CYCLES consecutive synchronized
// samples. On each alarm the synchronized sensor vector is snapshotted and a
// saturating event counter is bumped. The operator acknowledges with ack; a
// fault that is still present after the acknowledge must go away before a new
// alarm can be raised.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive error samples needed (legal range 2..255)
//   COUNT_WIDTH      width of event_count
//
// Ports:
//   clk            in   system clock, rising edge
//   n_rst          in   asynchronous active-low reset
//   error_in       in   raw sensor-fault flag (asynchronous)
//   sensors_in     in   [3:0] raw sensor vector (asynchronous)
//   ack            in   operator acknowledge (level), honoured only in ALARM
//   clr_count      in   synchronous clear of event_count (wins over increment)
//   alarm          out  registered alarm, high exactly while in ALARM
//   alarm_sensors  out  [3:0] sensor snapshot taken when the alarm was raised
//   event_count    out  [COUNT_WIDTH-1:0] number of alarms raised, saturating
// -----------------------------------------------------------------------------
module sensor_error_monitor
    import sensor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned COUNT_WIDTH     = COUNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   error_in,
    input  logic [SENSOR_W-1:0]    sensors_in,
    input  logic                   ack,
    input  logic                   clr_count,
    output logic                   alarm,
    output logic [SENSOR_W-1:0]    alarm_sensors,
    output logic [COUNT_WIDTH-1:0] event_count
);

    // The count reaching DEBOUNCE_CYCLES-1 while err_s is still high means
    // this edge is the DEBOUNCE_CYCLES-th consecutive error sample.
    localparam logic [DB_CNT_W-1:0]    DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    // ---------------------------------------------------------------------
    // Input synchronization: error flag and sensor vector share one 5-bit
    // synchronizer so they see identical latency. The sensor bits are not
    // gray-coded, so a snapshot taken while sensors_in is changing may mix
    // old and new bits; the sensor source is expected to hold its vector
    // while reporting a fault.
    // ---------------------------------------------------------------------
    logic [SENSOR_W:0]   sync_out;
    logic                err_s;
    logic [SENSOR_W-1:0] sens_s;

    sync_2ff #(
        .WIDTH (SENSOR_W + 1)
    ) u_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d_i   ({error_in, sensors_in}),
        .q_o   (sync_out)
    );

    assign err_s  = sync_out[SENSOR_W];
    assign sens_s = sync_out[SENSOR_W-1:0];

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_e                 state_q, state_d;
    logic [DB_CNT_W-1:0]    db_cnt_q, db_cnt_d;
    logic                   alarm_q, alarm_d;
    logic [SENSOR_W-1:0]    snap_q, snap_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   raise;

    // NOTE: every signal written in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a
    // latch.
    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        raise    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (err_s) begin
                    state_d  = ST_PENDING;
                    db_cnt_d = DB_CNT_W'(1);
                end else begin
                    db_cnt_d = '0;
                end
            end

            ST_PENDING: begin
                if (!err_s) begin
                    // Any clean sample restarts debounce from scratch.
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = ST_ALARM;
                    db_cnt_d = '0;
                    raise    = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_CNT_W'(1);
                end
            end

            ST_ALARM: begin
                db_cnt_d = '0;
                // The fault level is ignored until the operator acknowledges.
                if (ack) begin
                    state_d = err_s ? ST_ACKED : ST_IDLE;
                end
            end

            ST_ACKED: begin
                db_cnt_d = '0;
                // Fault must clear before re-arming; no new alarm meanwhile.
                if (!err_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                db_cnt_d = '0;
            end
        endcase
    end

    // Alarm is registered from the next state so the output is a clean flop
    // that tracks ALARM exactly, with no decode glitches on the pin.
    always_comb begin
        alarm_d = (state_d == ST_ALARM);
        snap_d  = raise ? sens_s : snap_q;

        if (clr_count) begin
            cnt_d = '0;
        end else if (raise && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            db_cnt_q <= '0;
            alarm_q  <= 1'b0;
            snap_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            db_cnt_q <= db_cnt_d;
            alarm_q  <= alarm_d;
            snap_q   <= snap_d;
            cnt_q    <= cnt_d;
        end
    end

    assign alarm         = alarm_q;
    assign alarm_sensors = snap_q;
    assign event_count   = cnt_q;

endmodule : sensor_error_monitor

// File: tb/tb_sensor_error_monitor.sv
// -----------------------------------------------------------------------------
// tb_sensor_error_monitor
// Scoreboard bench for sensor_error_monitor. Each stimulus step drives inputs
// on the falling edge and pushes the outputs expected after the following
// rising edge, computed by a run-length reference model of the alarm rules.
// A monitor pops one entry per rising edge (sampled #1 later) and compares.
// Directed scenarios add literal checks at the points of interest; a random
// phase exercises interleavings of faults, acks and clears.
// -----------------------------------------------------------------------------
module tb_sensor_error_monitor;

    localparam int DB   = 4;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          error_in = 1'b0;
    logic [3:0]    sensors_in = 4'h0;
    logic          ack = 1'b0;
    logic          clr_count = 1'b0;
    logic          alarm;
    logic [3:0]    alarm_sensors;
    logic [CW-1:0] event_count;

    always #5 clk = ~clk;

    sensor_error_monitor #(
        .DEBOUNCE_CYCLES (DB),
        .COUNT_WIDTH     (CW)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .error_in      (error_in),
        .sensors_in    (sensors_in),
        .ack           (ack),
        .clr_count     (clr_count),
        .alarm         (alarm),
        .alarm_sensors (alarm_sensors),
        .event_count   (event_count)
    );

    typedef struct packed {
        logic          alarm;
        logic [3:0]    sens;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: two-sample input delay, a run length of consecutive
    // error samples, a latched alarm, and a "wait for the fault to clear"
    // flag after an acknowledge that arrived while the fault was still there.
    bit         m_e1, m_e2;
    logic [3:0] m_s1, m_s2;
    int         m_run;
    bit         m_alarm;
    bit         m_wait;
    logic [3:0] m_snap;
    int         m_cnt;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_e1 = 1'b0; m_e2 = 1'b0;
        m_s1 = 4'h0; m_s2 = 4'h0;
        m_run = 0; m_alarm = 1'b0; m_wait = 1'b0;
        m_snap = 4'h0; m_cnt = 0;
    endtask

    task automatic model_edge(input bit e, input logic [3:0] s, input bit a, input bit c);
        bit         err_s;
        logic [3:0] sens_s;
        exp_t       x;
        err_s  = m_e2;
        sens_s = m_s2;
        if (m_alarm) begin
            if (a) begin
                m_alarm = 1'b0;
                m_wait  = err_s;
            end
        end else if (m_wait) begin
            if (!err_s) m_wait = 1'b0;
        end else if (err_s) begin
            m_run++;
            if (m_run == DB) begin
                m_alarm = 1'b1;
                m_run   = 0;
                m_snap  = sens_s;
                if (m_cnt < CMAX) m_cnt++;
            end
        end else begin
            m_run = 0;
        end
        if (c) m_cnt = 0;
        m_e2 = m_e1; m_e1 = e;
        m_s2 = m_s1; m_s1 = s;
        x.alarm = m_alarm;
        x.sens  = m_snap;
        x.cnt   = CW'(m_cnt);
        exp_q.push_back(x);
    endtask

    task automatic step(input bit e, input logic [3:0] s, input bit a, input bit c);
        @(negedge clk);
        error_in   = e;
        sensors_in = s;
        ack        = a;
        clr_count  = c;
        model_edge(e, s, a, c);
    endtask

    // Literal check of the outputs right after the edge of the last step.
    task automatic expect_now(input string tag, input bit a, input logic [3:0] s, input int c);
        @(posedge clk);
        #2;
        check({tag, "_alarm"}, {31'b0, alarm}, {31'b0, a});
        check({tag, "_sensors"}, {28'b0, alarm_sensors}, {28'b0, s});
        check({tag, "_count"}, {{(32-CW){1'b0}}, event_count}, c);
    endtask

    // Asynchronous reset applied between edges; outputs must drop at once.
    task automatic mid_reset(input string tag);
        @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        check({tag, "_alarm"}, {31'b0, alarm}, 32'd0);
        check({tag, "_sensors"}, {28'b0, alarm_sensors}, 32'd0);
        check({tag, "_count"}, {{(32-CW){1'b0}}, event_count}, 32'd0);
        model_reset();
        @(posedge clk);
        #3;
        n_rst = 1'b1;
    endtask

    // From IDLE with a clean synchronizer: six steps with the fault held
    // raise an alarm on the sixth edge; acknowledge it and settle back.
    task automatic raise_alarm(input logic [3:0] s, input bit clr_last, input int exp_cnt);
        for (int i = 0; i < 5; i++) step(1'b1, s, 1'b0, 1'b0);
        step(1'b1, s, 1'b0, clr_last);
        expect_now("sat", 1'b1, s, exp_cnt);
        for (int i = 0; i < 3; i++) step(1'b0, s, 1'b1, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    // Monitor: one expected entry per rising edge while out of reset.
    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (n_rst && exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("sb_alarm", {31'b0, alarm}, {31'b0, x.alarm});
                check("sb_sensors", {28'b0, alarm_sensors}, {28'b0, x.sens});
                check("sb_count", {{(32-CW){1'b0}}, event_count}, {{(32-CW){1'b0}}, x.cnt});
            end
        end
    end

    initial begin : stimulus
        bit e_cur;
        model_reset();

        // Reset state.
        #1;
        check("rst_alarm", {31'b0, alarm}, 32'd0);
        check("rst_sensors", {28'b0, alarm_sensors}, 32'd0);
        check("rst_count", {{(32-CW){1'b0}}, event_count}, 32'd0);
        @(posedge clk);
        #3;
        n_rst = 1'b1;

        // Fault held from edge 1: alarm after edge 2+DB, not before.
        for (int i = 0; i < 5; i++) step(1'b1, 4'b0110, 1'b0, 1'b0);
        expect_now("hold_pre", 1'b0, 4'h0, 0);
        step(1'b1, 4'b0110, 1'b0, 1'b0);
        expect_now("hold_alarm", 1'b1, 4'b0110, 1);

        // Ack while fault persists: no re-alarm for 20 cycles.
        step(1'b1, 4'b0110, 1'b1, 1'b0);
        expect_now("ack_hi", 1'b0, 4'b0110, 1);
        for (int i = 0; i < 20; i++) step(1'b1, 4'b0110, i[0], 1'b0);
        expect_now("acked_hold", 1'b0, 4'b0110, 1);

        // Fault clears, then returns: second alarm.
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 4'b1100, 1'b0, 1'b0);
        step(1'b1, 4'b1100, 1'b0, 1'b0);
        expect_now("second_alarm", 1'b1, 4'b1100, 2);
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b0);

        // Glitches of 3 high, 1 low, 3 high never reach DB samples.
        for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 1'b0, 1'b0);
        step(1'b0, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b0, 1'b0);
        expect_now("glitch", 1'b0, 4'b1100, 2);

        // Saturation of the 2-bit counter, clear coincident with increment.
        step(1'b0, 4'h0, 1'b0, 1'b1);
        expect_now("clr", 1'b0, 4'b1100, 0);
        raise_alarm(4'h1, 1'b0, 1);
        raise_alarm(4'h2, 1'b0, 2);
        raise_alarm(4'h3, 1'b0, 3);
        raise_alarm(4'h4, 1'b0, 3);
        raise_alarm(4'h5, 1'b1, 0);

        // Randomized phase: fault runs of varied length, random acks/clears.
        e_cur = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 15) e_cur = ~e_cur;
            step(e_cur, 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) < 2), ($urandom_range(0, 29) == 0));
        end

        // Reset in ALARM aborts the event; debounce restarts afterwards.
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 4'b1001, 1'b0, 1'b0);
        step(1'b1, 4'b1001, 1'b0, 1'b0);
        expect_now("pre_rst", 1'b1, 4'b1001, 1);
        step(1'b1, 4'b1001, 1'b0, 1'b0);
        mid_reset("mid_rst");
        for (int i = 0; i < 5; i++) step(1'b1, 4'b0011, 1'b0, 1'b0);
        expect_now("post_rst_pre", 1'b0, 4'h0, 0);
        step(1'b1, 4'b0011, 1'b0, 1'b0);
        expect_now("post_rst_alarm", 1'b1, 4'b0011, 1);

        // Every expected entry must have been consumed by the monitor.
        @(posedge clk);
        #2;
        check("sb_drain", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sensor_error_monitor

// File: doc/sensor_error_monitor.md
SENSOR_ERROR_MONITOR -- requirements
Module: sensor_error_monitor

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 4, consecutive synchronized error samples needed to raise alarm; legal range 2..255.
REQ-002 Parameter: COUNT_WIDTH, 8, width of the alarm event counter.
REQ-003 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port: n_rst  input  1  reset, asynchronous and active-low.
REQ-005 Port: error_in  input  1  raw sensor-fault flag from the sensor error detector; asynchronous to clk.
REQ-006 Port: sensors_in  input  4  raw sensor vector that produced error_in; asynchronous to clk.
REQ-007 Port: ack  input  1  operator acknowledge; level, sampled each edge.
REQ-008 Port: clr_count  input  1  synchronous clear of event_count.
REQ-009 Port: alarm  output  1  debounced, latched fault alarm.
REQ-010 Port: alarm_sensors  output  4  synchronized sensor snapshot taken when alarm was raised.
REQ-011 Port: event_count  output  COUNT_WIDTH  number of alarms raised, saturating.

Function
REQ-012 error_in and sensors_in SHALL each pass through a 2-flop synchronizer; err_s and sens_s denote the second-stage outputs.
REQ-013 FSM states SHALL be IDLE, PENDING, ALARM, ACKED.
REQ-014 IDLE: err_s=1 -> PENDING with debounce count=1; else stay.
REQ-015 PENDING: err_s=0 -> IDLE, count cleared; err_s=1 and count=DEBOUNCE_CYCLES-1 -> ALARM; else count+1.
REQ-016 ALARM: ack=1 and err_s=0 -> IDLE; ack=1 and err_s=1 -> ACKED; ack=0 -> stay, regardless of err_s.
REQ-017 ACKED: err_s=0 -> IDLE; else stay; no new alarm or count increment until IDLE is re-entered.
REQ-018 alarm SHALL be 1 exactly while in ALARM; registered output, no combinational path from inputs.
REQ-019 With error_in held high, alarm SHALL rise on edge 2+DEBOUNCE_CYCLES counted from the first edge sampling error_in=1.
REQ-020 A single err_s=0 sample in PENDING SHALL restart debounce; glitches shorter than DEBOUNCE_CYCLES never raise alarm.
REQ-021 On the PENDING->ALARM edge, alarm_sensors SHALL load sens_s; it SHALL hold until the next PENDING->ALARM transition.
REQ-022 On the PENDING->ALARM edge, event_count SHALL increment by 1, saturating at 2^COUNT_WIDTH-1 (no wrap).
REQ-023 clr_count=1 SHALL set event_count to 0 on that edge; if coincident with an increment, clear wins (result 0).
REQ-024 ack SHALL be ignored in IDLE, PENDING and ACKED.

Reset
REQ-025 n_rst=0 SHALL immediately force FSM to IDLE, debounce count 0, synchronizer flops 0, alarm 0, alarm_sensors 4'b0000, event_count 0.
REQ-026 Reset asserted mid-PENDING or mid-ALARM SHALL abort the event with no count increment; after release, debounce restarts from the synchronizer.

Structure
REQ-027 State enum and DEBOUNCE_CYCLES/COUNT_WIDTH defaults SHALL live in shared package sensor_pkg.
REQ-028 The synchronizer SHALL be one sub-module, sync_2ff (parameterized width, reset value 0), instantiated once, 5 bits wide.
REQ-029 Debounce counter width SHALL be 8 bits, sized for the maximum DEBOUNCE_CYCLES.

Verification
REQ-030 error_in=1, sensors_in=4'b0110 held from edge 1, DEBOUNCE_CYCLES=4 -> alarm=1 after edge 6, alarm_sensors=4'b0110, event_count=1.
REQ-031 error_in pulses high for 3 cycles, low 1, high 3 -> alarm stays 0, event_count stays 0.
REQ-032 In ALARM: ack=1 with error_in still 1 -> ACKED, alarm=0; error_in held 1 for 20 cycles -> no re-alarm; error_in=0 then 1 again -> second alarm, event_count=2.
REQ-033 COUNT_WIDTH=2, raise 5 alarms -> event_count=3 after the third and stays 3; clr_count coincident with the 5th increment -> 0.
REQ-034 n_rst pulsed low in ALARM with event_count=1 -> all outputs 0 asynchronously; after release, error_in held 1 -> alarm after 2+DEBOUNCE_CYCLES edges, event_count=1.
